// File: rtl/zxw_ifetch.sv
// zxw_ifetch - instruction prefetch stage.
//
// Walks a 14-bit fetch PC, reads 14-bit words from a synchronous program ROM
// (one cycle read latency) and queues {pc, word} pairs in a small FIFO. The
// execute controller takes words from the FIFO head through a valid/ready
// handshake. A redirect flushes every buffered and in-flight word and restarts
// fetching at a new PC after a one-cycle FLUSH state.
//
// Ports:
//   Clock_pin    in   rising-edge clock
//   Resetn_pin   in   asynchronous active-low reset
//   PM_addr      out  ROM address (low PM_AW bits of the fetch PC)
//   PM_rd        out  a fetch is issued at PM_addr this cycle
//   PM_data      in   ROM word for the address sampled at the previous edge
//   IR_out       out  instruction word at the FIFO head
//   PC_out       out  address of IR_out
//   IR_valid     out  FIFO head is valid
//   IR_ready     in   consumer takes the head this cycle
//   Redirect     in   flush and restart fetching at Redirect_PC
//   Redirect_PC  in   new fetch PC, sampled while Redirect=1
module zxw_ifetch #(
    parameter int DEPTH = 4,
    parameter int PM_AW = 10
) (
    input  logic             Clock_pin,
    input  logic             Resetn_pin,
    output logic [PM_AW-1:0] PM_addr,
    output logic             PM_rd,
    input  logic [13:0]      PM_data,
    output logic [13:0]      IR_out,
    output logic [13:0]      PC_out,
    output logic             IR_valid,
    input  logic             IR_ready,
    input  logic             Redirect,
    input  logic [13:0]      Redirect_PC
);

    localparam int PW = $clog2(DEPTH);
    // Wide enough to hold count + inflight, which can reach DEPTH.
    localparam int CW = $clog2(DEPTH + 2);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t          state_r;
    logic [13:0]     fpc_r;
    logic            inflight_r;
    logic [13:0]     inflight_pc_r;
    logic [CW-1:0]   count_r;
    logic [PW-1:0]   head_r;
    logic [PW-1:0]   tail_r;
    logic [13:0]     fifo_pc_r   [DEPTH];
    logic [13:0]     fifo_word_r [DEPTH];

    logic [CW-1:0]   occ_s;
    logic            issue_s;
    logic            push_s;
    logic            pop_s;
    logic            valid_s;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    // Issue/push/pop decisions from registered state.
    always_comb begin
        occ_s   = count_r + CW'(inflight_r);
        valid_s = (count_r != {CW{1'b0}});
        // Occupancy includes the in-flight word so a returning word always
        // finds a free slot; a same-cycle pop is deliberately not credited.
        if ((state_r == ST_RUN) && (occ_s < DEPTH_C)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        // A word returning while Redirect is high belongs to the old stream.
        if (inflight_r && !Redirect) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (valid_s && IR_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign PM_addr  = fpc_r[PM_AW-1:0];
    // Forced low while reset is held so the ROM sees no read during reset.
    assign PM_rd    = issue_s & Resetn_pin;
    assign IR_valid = valid_s;
    assign IR_out   = fifo_word_r[head_r];
    assign PC_out   = fifo_pc_r[head_r];

    // Control FSM, fetch PC, in-flight tracking and FIFO pointers/count.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            state_r       <= ST_RUN;
            fpc_r         <= 14'h0000;
            inflight_r    <= 1'b0;
            inflight_pc_r <= 14'h0000;
            count_r       <= {CW{1'b0}};
            head_r        <= {PW{1'b0}};
            tail_r        <= {PW{1'b0}};
        end else if (Redirect) begin
            // Flush everything; a concurrent pop is simply absorbed.
            state_r    <= ST_FLUSH;
            fpc_r      <= Redirect_PC;
            inflight_r <= 1'b0;
            count_r    <= {CW{1'b0}};
            head_r     <= {PW{1'b0}};
            tail_r     <= {PW{1'b0}};
        end else begin
            case (state_r)
                ST_RUN:   state_r <= ST_RUN;
                ST_FLUSH: state_r <= ST_RUN;
                default:  state_r <= ST_RUN;
            endcase

            if (issue_s) begin
                inflight_r    <= 1'b1;
                inflight_pc_r <= fpc_r;
                fpc_r         <= fpc_r + 14'd1;
            end else begin
                inflight_r    <= 1'b0;
            end

            if (push_s) begin
                tail_r <= ptr_inc(tail_r);
            end
            if (pop_s) begin
                head_r <= ptr_inc(head_r);
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage: the returning ROM word is written with its fetch address.
    always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
        if (!Resetn_pin) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_r[i]   <= 14'h0000;
                fifo_word_r[i] <= 14'h0000;
            end
        end else if (push_s) begin
            fifo_pc_r[tail_r]   <= inflight_pc_r;
            fifo_word_r[tail_r] <= PM_data;
        end
    end

endmodule

// File: tb/tb_zxw_ifetch.sv
// Directed self-checking bench for zxw_ifetch (DEPTH=4, PM_AW=10).
// The ROM model returns 0x1000 + address one cycle after the address is
// sampled. Inputs change and outputs are sampled 1 time unit after each
// rising edge.
module tb_zxw_ifetch;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pm_addr;
    logic        pm_rd;
    logic [13:0] pm_data;
    logic [13:0] ir_out;
    logic [13:0] pc_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [13:0] redirect_pc;

    int n_cmp;
    int n_err;
    int max_cnt;
    logic ovf_seen;

    zxw_ifetch #(.DEPTH(4), .PM_AW(10)) dut (
        .Clock_pin   (clk),
        .Resetn_pin  (rst_n),
        .PM_addr     (pm_addr),
        .PM_rd       (pm_rd),
        .PM_data     (pm_data),
        .IR_out      (ir_out),
        .PC_out      (pc_out),
        .IR_valid    (ir_valid),
        .IR_ready    (ir_ready),
        .Redirect    (redirect),
        .Redirect_PC (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model.
    initial pm_data = 14'h0000;
    always @(posedge clk) pm_data <= 14'h1000 + {4'b0000, pm_addr};

    // Occupancy watch: track the peak count and any push into a full FIFO.
    always @(negedge clk) begin
        if (rst_n) begin
            if (int'(dut.count_r) > max_cnt) max_cnt = int'(dut.count_r);
            if (dut.push_s && !dut.pop_s && (dut.count_r == 3'd4)) ovf_seen = 1'b1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_rst();
        rst_n    = 1'b0;
        redirect = 1'b0;
        ir_ready = 1'b0;
        step();
        step();
    endtask

    // Release reset between edges; the next edge is cycle 0 and issues PC 0.
    task automatic release_rst(input logic rdy);
        rst_n    = 1'b1;
        ir_ready = rdy;
        #1;
        check_eq("rel_rd", 32'(pm_rd), 32'd1);
        check_eq("rel_addr", 32'(pm_addr), 32'h000);
    endtask

    // Streaming with IR_ready=1: first valid after edge 1, then no gaps.
    task automatic stream_check(input string tag);
        step();
        check_eq({tag, "_v0"}, 32'(ir_valid), 32'd0);
        step();
        for (int k = 0; k < 6; k++) begin
            check_eq({tag, "_valid"}, 32'(ir_valid), 32'd1);
            check_eq({tag, "_pc"}, 32'(pc_out), 32'(k));
            check_eq({tag, "_ir"}, 32'(ir_out), 32'h1000 + 32'(k));
            step();
        end
    endtask

    initial begin
        int rd_cnt;
        int next_pc;
        int accepted;
        n_cmp    = 0;
        n_err    = 0;
        max_cnt  = 0;
        ovf_seen = 1'b0;
        rst_n       = 1'b0;
        ir_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 14'h0000;
        step();
        step();
        step();

        // Reset state.
        check_eq("rst_valid", 32'(ir_valid), 32'd0);
        check_eq("rst_rd", 32'(pm_rd), 32'd0);
        check_eq("rst_addr", 32'(pm_addr), 32'h000);
        check_eq("rst_ir", 32'(ir_out), 32'h0000);
        check_eq("rst_pc", 32'(pc_out), 32'h0000);

        // Scenario 1: streaming after reset.
        release_rst(1'b1);
        stream_check("s1");

        // Scenario 2: consumer stalled, FIFO fills, then a single pop.
        apply_rst();
        release_rst(1'b0);
        for (int i = 0; i < 6; i++) step();
        check_eq("s2_full_rd", 32'(pm_rd), 32'd0);
        check_eq("s2_hold_v", 32'(ir_valid), 32'd1);
        check_eq("s2_hold_pc", 32'(pc_out), 32'h0000);
        check_eq("s2_hold_ir", 32'(ir_out), 32'h1000);
        ir_ready = 1'b1;
        check_eq("s2_no_credit", 32'(pm_rd), 32'd0);
        step();
        ir_ready = 1'b0;
        check_eq("s2_pop_pc", 32'(pc_out), 32'h0001);
        rd_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            rd_cnt += int'(pm_rd);
            step();
        end
        check_eq("s2_one_fetch", 32'(rd_cnt), 32'd1);
        check_eq("s2_stable_pc", 32'(pc_out), 32'h0001);
        ir_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("s2_drain_v", 32'(ir_valid), 32'd1);
            check_eq("s2_drain_pc", 32'(pc_out), 32'(k));
            step();
        end

        // Scenario 3: consumer accepts one cycle in four.
        apply_rst();
        release_rst(1'b0);
        next_pc  = 0;
        accepted = 0;
        for (int c = 0; c < 48; c++) begin
            ir_ready = ((c % 4) == 3);
            if (ir_valid && ir_ready) begin
                check_eq("s3_seq_pc", 32'(pc_out), 32'(next_pc));
                check_eq("s3_seq_ir", 32'(ir_out), 32'h1000 + 32'(next_pc));
                next_pc++;
                accepted++;
            end
            step();
        end
        ir_ready = 1'b0;
        check_eq("s3_accepted", 32'(accepted), 32'd12);
        check_eq("s3_max_count", 32'(max_cnt <= 4), 32'd1);

        // Scenario 4: redirect with three words queued and one in flight.
        apply_rst();
        release_rst(1'b0);
        for (int i = 0; i < 4; i++) step();
        redirect    = 1'b1;
        redirect_pc = 14'h0123;
        step();
        redirect = 1'b0;
        check_eq("s4_r1_valid", 32'(ir_valid), 32'd0);
        check_eq("s4_r1_rd", 32'(pm_rd), 32'd0);
        step();
        check_eq("s4_r2_rd", 32'(pm_rd), 32'd1);
        check_eq("s4_r2_addr", 32'(pm_addr), 32'h123);
        check_eq("s4_r2_valid", 32'(ir_valid), 32'd0);
        step();
        check_eq("s4_r3_valid", 32'(ir_valid), 32'd0);
        step();
        check_eq("s4_first_v", 32'(ir_valid), 32'd1);
        check_eq("s4_first_pc", 32'(pc_out), 32'h0123);
        check_eq("s4_first_ir", 32'(ir_out), 32'h1123);
        ir_ready = 1'b1;
        step();
        check_eq("s4_next_pc", 32'(pc_out), 32'h0124);
        step();
        check_eq("s4_next2_pc", 32'(pc_out), 32'h0125);

        // Scenario 5: redirect near the top of the PC space, wrap and alias.
        redirect    = 1'b1;
        redirect_pc = 14'h3FFE;
        step();
        redirect = 1'b0;
        check_eq("s5_flush_rd", 32'(pm_rd), 32'd0);
        check_eq("s5_flush_v", 32'(ir_valid), 32'd0);
        step();
        check_eq("s5_addr0", 32'(pm_addr), 32'h3FE);
        check_eq("s5_rd0", 32'(pm_rd), 32'd1);
        step();
        check_eq("s5_addr1", 32'(pm_addr), 32'h3FF);
        check_eq("s5_v_wait", 32'(ir_valid), 32'd0);
        step();
        check_eq("s5_addr2", 32'(pm_addr), 32'h000);
        check_eq("s5_pc0", 32'(pc_out), 32'h3FFE);
        check_eq("s5_ir0", 32'(ir_out), 32'h13FE);
        step();
        check_eq("s5_pc1", 32'(pc_out), 32'h3FFF);
        check_eq("s5_ir1", 32'(ir_out), 32'h13FF);
        step();
        check_eq("s5_pc2", 32'(pc_out), 32'h0000);
        check_eq("s5_ir2", 32'(ir_out), 32'h1000);
        step();
        check_eq("s5_pc3", 32'(pc_out), 32'h0001);
        check_eq("s5_ir3", 32'(ir_out), 32'h1001);

        // Scenario 6: reset pulsed mid-cycle while three words are queued.
        apply_rst();
        release_rst(1'b0);
        for (int i = 0; i < 4; i++) step();
        check_eq("s6_pre_v", 32'(ir_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s6_async_v", 32'(ir_valid), 32'd0);
        check_eq("s6_async_addr", 32'(pm_addr), 32'h000);
        check_eq("s6_async_rd", 32'(pm_rd), 32'd0);
        step();
        step();
        release_rst(1'b1);
        stream_check("s6");

        check_eq("no_overflow", 32'(ovf_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
